// File: rtl/proc_pkg.sv
// proc_pkg: shared processor-level constants and types.
//   XLEN_DEFAULT  default address/PC width
//   PC_RESET_VAL  PC value loaded by pc_gen on reset
//   pc_state_e    pc_gen FSM state encoding (exposed on state_o)
package proc_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_fetch_cnt.sv
// pc_fetch_cnt: 64-bit free-running enable counter, wraps at 2^64.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  synchronous active-low reset (clears count)
//   en_i     increment enable
//   cnt_o    current count
module pc_fetch_cnt (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= 64'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator, sole source of fetch addresses.
// Next-PC priority each cycle: trap > redirect > fetch-accept increment > hold.
// Optional feature macro: PC_FETCH_CNT_EN adds fetch_cnt_o (count of accepted
// fetches); without it the port and counter are absent.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   pc_o, pc_valid_o      fetch address and its valid (valid only in RUN)
//   pc_ready_i            fetch stage accepts pc_o this cycle
//   redirect_i/_pc_i      branch/jump redirect and target
//   trap_i, trap_vec_i    trap and vector base (low 2 bits are mode, ignored)
//   halt_i, resume_i      halt request / leave HALT
//   misalign_o            one-cycle pulse after a misaligned redirect
//   state_o               current FSM state (pc_state_e)
//   fetch_cnt_o           accepted-fetch count (PC_FETCH_CNT_EN only)
module pc_gen
    import proc_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VAL),
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic            misalign_o,
    output logic [1:0]      state_o
`ifdef PC_FETCH_CNT_EN
    ,
    output logic [63:0]     fetch_cnt_o
`endif
);

    // Mask form of the low ALIGN_BITS so INSTR_BYTES=1 needs no zero-width slice.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] TRAP_MASK  = XLEN'(3);

    logic [XLEN-1:0] pc_q;
    pc_state_e       state_q;
    logic            halt_pend_q;
    logic            misalign_q;

    logic            valid;
    logic            fire;
    logic            stall;
    logic            redir_misaligned;
    logic [XLEN-1:0] trap_pc;

    assign valid            = (state_q == PC_RUN);
    assign fire             = valid & pc_ready_i;
    assign stall            = valid & ~pc_ready_i;
    assign redir_misaligned = |(redirect_pc_i & ALIGN_MASK);
    assign trap_pc          = trap_vec_i & ~TRAP_MASK;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q        <= RESET_VEC;
            state_q     <= PC_BOOT;
            halt_pend_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;

            // Next PC. Clearing the alignment bits is a no-op for aligned targets.
            if (trap_i) begin
                pc_q <= trap_pc;
            end else if (redirect_i) begin
                pc_q <= redirect_pc_i & ~ALIGN_MASK;
            end else if (fire) begin
                pc_q <= pc_q + PC_INC;
            end

            // FSM. Trap wakes from any state; a misaligned redirect parks in HALT.
            if (trap_i) begin
                state_q     <= PC_RUN;
                halt_pend_q <= 1'b0;
            end else if (redirect_i && redir_misaligned) begin
                state_q     <= PC_HALT;
                halt_pend_q <= 1'b0;
                misalign_q  <= 1'b1;
            end else begin
                case (state_q)
                    PC_BOOT: state_q <= PC_RUN;
                    PC_RUN: begin
                        // A stalled request must not be withdrawn, so the halt
                        // waits until the fetch stage has taken pc_o.
                        if ((halt_pend_q || halt_i) && !stall) begin
                            state_q     <= PC_HALT;
                            halt_pend_q <= 1'b0;
                        end else if (halt_i) begin
                            halt_pend_q <= 1'b1;
                        end
                    end
                    PC_HALT: begin
                        if (resume_i) begin
                            state_q <= PC_RUN;
                        end
                    end
                    default: state_q <= PC_BOOT;
                endcase
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid;
    assign misalign_o = misalign_q;
    assign state_o    = state_q;

`ifdef PC_FETCH_CNT_EN
    pc_fetch_cnt u_fetch_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (fire),
        .cnt_o   (fetch_cnt_o)
    );
`else
    // No fetch counter in this build.
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_vec;
    logic        halt;
    logic        resume;
    logic        misalign;
    logic [1:0]  state;
`ifdef PC_FETCH_CNT_EN
    logic [63:0] fetch_cnt;
`endif

    always #5 clk = ~clk;

    pc_gen dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pc_o          (pc),
        .pc_valid_o    (pc_valid),
        .pc_ready_i    (pc_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .trap_i        (trap),
        .trap_vec_i    (trap_vec),
        .halt_i        (halt),
        .resume_i      (resume),
        .misalign_o    (misalign),
        .state_o       (state)
`ifdef PC_FETCH_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic [1:0]  st;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        exp_valid_prev = 1'b0;
    logic [63:0] exp_cnt = 64'd0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock, then pop and compare.
    task automatic cyc(input string tag, input logic [31:0] e_pc, input logic e_valid,
                       input logic [1:0] e_st, input logic e_mis);
        exp_t e;
        exp_t g;
        if (!rst_n) exp_cnt = 64'd0;
        else if (exp_valid_prev && pc_ready) exp_cnt = exp_cnt + 64'd1;
        exp_valid_prev = rst_n ? e_valid : 1'b0;
        e.tag = tag; e.pc = e_pc; e.valid = e_valid; e.st = e_st; e.mis = e_mis; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            g = sb.pop_front();
            check({g.tag, ".pc"},       {32'd0, pc},       {32'd0, g.pc});
            check({g.tag, ".valid"},    {63'd0, pc_valid}, {63'd0, g.valid});
            check({g.tag, ".state"},    {62'd0, state},    {62'd0, g.st});
            check({g.tag, ".misalign"}, {63'd0, misalign}, {63'd0, g.mis});
`ifdef PC_FETCH_CNT_EN
            check({g.tag, ".fetch_cnt"}, fetch_cnt, g.cnt);
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; pc_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        trap = 1'b0; trap_vec = 32'h0; halt = 1'b0; resume = 1'b0;

        // Reset and boot
        cyc("rst0", 32'h0, 1'b0, PC_BOOT, 1'b0);
        cyc("rst1", 32'h0, 1'b0, PC_BOOT, 1'b0);
        rst_n = 1'b1;
        cyc("boot_to_run", 32'h0, 1'b1, PC_RUN, 1'b0);
        cyc("seq4",  32'h4,  1'b1, PC_RUN, 1'b0);
        cyc("seq8",  32'h8,  1'b1, PC_RUN, 1'b0);
        cyc("seqC",  32'hC,  1'b1, PC_RUN, 1'b0);
        cyc("seq10", 32'h10, 1'b1, PC_RUN, 1'b0);

        // Stall holds pc, then resumes increment
        pc_ready = 1'b0;
        cyc("stall1", 32'h10, 1'b1, PC_RUN, 1'b0);
        cyc("stall2", 32'h10, 1'b1, PC_RUN, 1'b0);
        cyc("stall3", 32'h10, 1'b1, PC_RUN, 1'b0);
        pc_ready = 1'b1;
        cyc("unstall", 32'h14, 1'b1, PC_RUN, 1'b0);

        // Redirect flushes a stalled request
        pc_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        cyc("redir_stall", 32'h100, 1'b1, PC_RUN, 1'b0);
        redirect = 1'b0;
        cyc("redir_hold", 32'h100, 1'b1, PC_RUN, 1'b0);

        // Trap beats redirect; mode bits dropped
        trap = 1'b1; trap_vec = 32'h8000_0003; redirect = 1'b1; redirect_pc = 32'h200;
        cyc("trap_vs_redir", 32'h8000_0000, 1'b1, PC_RUN, 1'b0);
        trap = 1'b0; redirect = 1'b0;

        // Misaligned redirect -> HALT with one-cycle pulse
        redirect = 1'b1; redirect_pc = 32'h102;
        cyc("misalign", 32'h100, 1'b0, PC_HALT, 1'b1);
        redirect = 1'b0; pc_ready = 1'b1;
        cyc("mis_pulse_end", 32'h100, 1'b0, PC_HALT, 1'b0);
        cyc("halt_hold", 32'h100, 1'b0, PC_HALT, 1'b0);
        resume = 1'b1; halt = 1'b1;
        cyc("resume_wins", 32'h100, 1'b1, PC_RUN, 1'b0);
        resume = 1'b0; halt = 1'b0;
        cyc("resume_fetch", 32'h104, 1'b1, PC_RUN, 1'b0);

        // Halt requested during stall waits for the fire
        redirect = 1'b1; redirect_pc = 32'h20;
        cyc("redir_beats_fire", 32'h20, 1'b1, PC_RUN, 1'b0);
        redirect = 1'b0; pc_ready = 1'b0; halt = 1'b1;
        cyc("halt_stalled", 32'h20, 1'b1, PC_RUN, 1'b0);
        halt = 1'b0;
        cyc("halt_pend", 32'h20, 1'b1, PC_RUN, 1'b0);
        pc_ready = 1'b1;
        cyc("halt_on_fire", 32'h24, 1'b0, PC_HALT, 1'b0);
        halt = 1'b1;
        cyc("halt_in_halt", 32'h24, 1'b0, PC_HALT, 1'b0);
        halt = 1'b0; trap = 1'b1; trap_vec = 32'h300;
        cyc("trap_wakes", 32'h300, 1'b1, PC_RUN, 1'b0);
        trap = 1'b0;
        cyc("after_trap", 32'h304, 1'b1, PC_RUN, 1'b0);

        // Wrap at 2^32
        pc_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc("to_top", 32'hFFFF_FFFC, 1'b1, PC_RUN, 1'b0);
        redirect = 1'b0; pc_ready = 1'b1;
        cyc("wrap", 32'h0, 1'b1, PC_RUN, 1'b0);
        cyc("wrap_next", 32'h4, 1'b1, PC_RUN, 1'b0);

        // Mid-run reset discards a pending halt
        pc_ready = 1'b0; halt = 1'b1;
        cyc("pend_pre_rst", 32'h4, 1'b1, PC_RUN, 1'b0);
        halt = 1'b0; rst_n = 1'b0;
        cyc("mid_rst", 32'h0, 1'b0, PC_BOOT, 1'b0);
        rst_n = 1'b1; pc_ready = 1'b1;
        cyc("post_rst_boot", 32'h0, 1'b1, PC_RUN, 1'b0);
        cyc("pend_dropped", 32'h4, 1'b1, PC_RUN, 1'b0);
        cyc("post_rst_seq", 32'h8, 1'b1, PC_RUN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
